// File: rtl/nios_td3_memtest_pkg.sv
// Shared types and helpers for the Avalon-MM memory test master.
// Holds the FSM state encoding, the error counter width and the
// test pattern function P(a) = seed ^ a (optionally inverted).
// Optional feature macro used by the master: MEMTEST_INVERT_PASS_EN.
package nios_td3_memtest_pkg;

   localparam int unsigned ERR_CNT_W = 16;
   // Widest data/address the pattern helper supports; callers cast down.
   localparam int unsigned PAT_MAX_W = 256;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      FIN   = 3'd4
   } state_e;

   // Pattern for one word: seed XOR zero-extended address, inverted on request.
   function automatic logic [PAT_MAX_W-1:0] pattern_f(input logic [PAT_MAX_W-1:0] seed_i,
                                                      input logic [PAT_MAX_W-1:0] addr_i,
                                                      input logic             inv_i);
      logic [PAT_MAX_W-1:0] p;
      p = seed_i ^ addr_i;
      return inv_i ? ~p : p;
   endfunction

endpackage

// File: rtl/nios_td3_memtest_cmp.sv
// Read-data checker for the memory test master.
// Registers each issued read (address + expected word), compares the
// returned data one cycle later, and keeps a sticky error flag, a
// saturating mismatch counter and the address of the first mismatch.
// Ports: clk, reset_n (sync, active-low), clr (start of a new test),
//        issue_valid/issue_addr/issue_exp (read issued this cycle),
//        rdata (memory read data), err, err_count, first_err_addr.
module nios_td3_memtest_cmp
   import nios_td3_memtest_pkg::*;
#(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clr,
   input  logic                 issue_valid,
   input  logic [ADDR_W-1:0]    issue_addr,
   input  logic [DATA_W-1:0]    issue_exp,
   input  logic [DATA_W-1:0]    rdata,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [ADDR_W-1:0]    first_err_addr
);

   logic                 pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0]    pend_addr_q, pend_addr_d;
   logic [DATA_W-1:0]    pend_exp_q, pend_exp_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0]    fea_q, fea_d;
   logic                 mism_c;

   // Read data lands one cycle after issue, so compare against the piped request.
   always_comb begin
      pend_valid_d = issue_valid;
      pend_addr_d  = issue_addr;
      pend_exp_d   = issue_exp;
      err_d        = err_q;
      cnt_d        = cnt_q;
      fea_d        = fea_q;
      mism_c       = pend_valid_q && (rdata != pend_exp_q);
      if (clr) begin
         err_d = 1'b0;
         cnt_d = '0;
         fea_d = '0;
      end else if (mism_c) begin
         err_d = 1'b1;
         if (cnt_q != '1) cnt_d = ERR_CNT_W'(cnt_q + 1'b1);
         if (!err_q)      fea_d = pend_addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_exp_q   <= '0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         fea_q        <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_exp_q   <= pend_exp_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         fea_q        <= fea_d;
      end
   end

   assign err            = err_q;
   assign err_count      = cnt_q;
   assign first_err_addr = fea_q;

endmodule

// File: rtl/nios_td3_memtest_master.sv
// Avalon-MM memory test master: writes P(a) over a word range, reads it
// back and counts mismatches. Start-to-done latency is 2*word_count+2.
// Ports: clk, reset_n (sync, active-low), start/base_addr/word_count/seed
//        (test request), busy/done/err/err_count/first_err_addr (status),
//        m_* (Avalon-MM master, fixed 1-cycle read latency, no waitrequest).
// Macro MEMTEST_INVERT_PASS_EN adds a second pass with ~P(a)
// (latency 4*word_count+3).
module nios_td3_memtest_master
   import nios_td3_memtest_pkg::*;
#(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [ADDR_W:0]      word_count,
   input  logic [DATA_W-1:0]    seed,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [ADDR_W-1:0]    first_err_addr,
   output logic [ADDR_W-1:0]    m_address,
   output logic [DATA_W/8-1:0]  m_byteenable,
   output logic                 m_chipselect,
   output logic                 m_write,
   output logic [DATA_W-1:0]    m_writedata,
   input  logic [DATA_W-1:0]    m_readdata
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  remain_q, remain_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] seed_q, seed_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              cs_q, cs_d, wr_q, wr_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              clr_c, inv_c;
   logic [ADDR_W-1:0] addr_inc_c;
   logic [DATA_W-1:0] rd_exp_c;
`ifdef MEMTEST_INVERT_PASS_EN
   logic              pass_q, pass_d;
   assign inv_c = pass_q;
`else
   assign inv_c = 1'b0;
`endif

   function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] s,
                                             input logic [ADDR_W-1:0] a,
                                             input logic              inv);
      return DATA_W'(pattern_f(PAT_MAX_W'(s), PAT_MAX_W'(a), inv));
   endfunction

   // Address increment wraps modulo 2^ADDR_W.
   assign addr_inc_c = ADDR_W'(addr_q + 1'b1);
   assign rd_exp_c   = pat(seed_q, addr_q, inv_c);

   // Next-state and registered bus outputs; remain counts accesses left after this one.
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      count_d  = count_q;
      base_d   = base_q;
      seed_d   = seed_q;
      addr_d   = addr_q;
      wdata_d  = '0;
      cs_d     = 1'b0;
      wr_d     = 1'b0;
      done_d   = 1'b0;
      clr_c    = 1'b0;
`ifdef MEMTEST_INVERT_PASS_EN
      pass_d   = pass_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               clr_c   = 1'b1;
               base_d  = base_addr;
               count_d = word_count;
               seed_d  = seed;
`ifdef MEMTEST_INVERT_PASS_EN
               pass_d  = 1'b0;
`endif
               if (word_count == '0) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d  = WRITE;
                  cs_d     = 1'b1;
                  wr_d     = 1'b1;
                  addr_d   = base_addr;
                  wdata_d  = pat(seed, base_addr, 1'b0);
                  remain_d = CNT_W'(word_count - 1'b1);
               end
            end
         end
         WRITE: begin
            cs_d = 1'b1;
            if (remain_q == '0) begin
               state_d  = READ;
               addr_d   = base_q;
               remain_d = CNT_W'(count_q - 1'b1);
            end else begin
               wr_d     = 1'b1;
               addr_d   = addr_inc_c;
               wdata_d  = pat(seed_q, addr_inc_c, inv_c);
               remain_d = CNT_W'(remain_q - 1'b1);
            end
         end
         READ: begin
            if (remain_q == '0) begin
               state_d = DRAIN;
            end else begin
               cs_d     = 1'b1;
               addr_d   = addr_inc_c;
               remain_d = CNT_W'(remain_q - 1'b1);
            end
         end
         DRAIN: begin
`ifdef MEMTEST_INVERT_PASS_EN
            if (!pass_q) begin
               pass_d   = 1'b1;
               state_d  = WRITE;
               cs_d     = 1'b1;
               wr_d     = 1'b1;
               addr_d   = base_q;
               wdata_d  = pat(seed_q, base_q, 1'b1);
               remain_d = CNT_W'(count_q - 1'b1);
            end else begin
               state_d = FIN;
               done_d  = 1'b1;
            end
`else
            state_d = FIN;
            done_d  = 1'b1;
`endif
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         remain_q <= '0;
         count_q  <= '0;
         base_q   <= '0;
         seed_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cs_q     <= 1'b0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef MEMTEST_INVERT_PASS_EN
         pass_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         count_q  <= count_d;
         base_q   <= base_d;
         seed_q   <= seed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cs_q     <= cs_d;
         wr_q     <= wr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef MEMTEST_INVERT_PASS_EN
         pass_q   <= pass_d;
`endif
      end
   end

   nios_td3_memtest_cmp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cmp (
      .clk            (clk),
      .reset_n        (reset_n),
      .clr            (clr_c),
      .issue_valid    (cs_q & ~wr_q),
      .issue_addr     (addr_q),
      .issue_exp      (rd_exp_c),
      .rdata          (m_readdata),
      .err            (err),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   assign busy         = busy_q;
   assign done         = done_q;
   assign m_address    = addr_q;
   assign m_byteenable = '1;
   assign m_chipselect = cs_q;
   assign m_write      = wr_q;
   assign m_writedata  = wdata_q;

endmodule

// File: tb/tb_nios_td3_memtest_master.sv
// Directed bench for nios_td3_memtest_master against a 1-cycle-latency model RAM.
module tb_nios_td3_memtest_master;

`ifdef MEMTEST_INVERT_PASS_EN
   localparam int NPASS = 2;
`else
   localparam int NPASS = 1;
`endif

   logic        clk = 1'b0;
   logic        reset_n, start;
   logic [14:0] base_addr;
   logic [15:0] word_count;
   logic [31:0] seed;
   logic        busy, done, err;
   logic [15:0] err_count;
   logic [14:0] first_err_addr, m_address;
   logic [3:0]  m_byteenable;
   logic        m_chipselect, m_write;
   logic [31:0] m_writedata, m_readdata;

   nios_td3_memtest_master #(.ADDR_W(15), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .word_count(word_count), .seed(seed), .busy(busy), .done(done), .err(err),
      .err_count(err_count), .first_err_addr(first_err_addr), .m_address(m_address),
      .m_byteenable(m_byteenable), .m_chipselect(m_chipselect), .m_write(m_write),
      .m_writedata(m_writedata), .m_readdata(m_readdata));

   always #5 clk = ~clk;

   // Model RAM: read data valid the cycle after the read access.
   logic [31:0] ram [0:32767];
   logic        fault_en = 1'b0;
   logic [14:0] fault_addr = 15'h0;
   always @(posedge clk) begin
      if (m_chipselect && m_write) ram[m_address] <= m_writedata;
      if (m_chipselect && !m_write)
         m_readdata <= ram[m_address] ^ ((fault_en && m_address == fault_addr) ? 32'h1 : 32'h0);
   end

   typedef struct {
      logic        wr;
      logic [14:0] addr;
      logic [31:0] data;
      int          cyc;
   } acc_t;
   acc_t        acc_q[$];
   int          cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, busy_cnt = 0;
   bit          start_seen = 0;
   logic        err_at_done;
   logic [15:0] cnt_at_done;
   logic [14:0] fea_at_done;
   int          n_checks = 0, n_pass = 0;

   // Bus/status monitor sampled on the falling edge.
   always @(negedge clk) begin
      acc_t a;
      cyc = cyc + 1;
      if (start && !start_seen) begin start_seen = 1; start_cyc = cyc; end
      if (m_chipselect) begin
         a.wr = m_write; a.addr = m_address; a.data = m_writedata; a.cyc = cyc;
         acc_q.push_back(a);
      end
      if (busy) busy_cnt++;
      if (done) begin
         if (done_cnt == 0) begin
            done_cyc = cyc; err_at_done = err; cnt_at_done = err_count; fea_at_done = first_err_addr;
         end
         done_cnt++;
      end
   end

   task automatic start_test(input logic [14:0] b, input logic [15:0] n, input logic [31:0] s);
      @(posedge clk); #1;
      acc_q.delete(); done_cnt = 0; busy_cnt = 0; start_seen = 0;
      base_addr = b; word_count = n; seed = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      for (int i = 0; i < budget; i++) begin
         if (done_cnt != 0) break;
         @(posedge clk);
      end
      ok = (done_cnt != 0);
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({busy, done, err, err_count, first_err_addr, m_chipselect, m_write, m_address, m_writedata} !== 83'd0)
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b cnt=%h fea=%h cs=%b wr=%b addr=%h wd=%h, want all 0",
                  busy, done, err, err_count, first_err_addr, m_chipselect, m_write, m_address, m_writedata);
      else n_pass++;
      n_checks++;
      if (m_byteenable !== 4'hF) $display("FAIL byteenable: got %h want f", m_byteenable);
      else n_pass++;
      @(posedge clk); #1; reset_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] exp_d [4];
      bit ok;
      int p, r, i;
      exp_d = '{32'hA5A5A5B5, 32'hA5A5A5B4, 32'hA5A5A5B7, 32'hA5A5A5B6};
      start_test(15'h0010, 16'd4, 32'hA5A5A5A5);
      wait_done(60, ok);
      n_checks++;
      if (!ok) $display("FAIL basic_done_timeout: no done, want done");
      else n_pass++;
      n_checks++;
      if (acc_q.size() != 8 * NPASS) $display("FAIL basic_access_count: got %0d want %0d", acc_q.size(), 8 * NPASS);
      else n_pass++;
      for (int k = 0; k < acc_q.size() && k < 8 * NPASS; k++) begin
         p = k / 8; r = k % 8; i = r % 4;
         n_checks++;
         if (acc_q[k].wr !== (r < 4) || acc_q[k].addr !== 15'(16 + i) || acc_q[k].cyc != start_cyc + 1 + p * 9 + r ||
             (r < 4 && acc_q[k].data !== (p == 1 ? ~exp_d[i] : exp_d[i])))
            $display("FAIL basic_access[%0d]: got wr=%b addr=%h data=%h cyc=+%0d", k, acc_q[k].wr, acc_q[k].addr,
                     acc_q[k].data, acc_q[k].cyc - start_cyc);
         else n_pass++;
      end
      n_checks++;
      if (done_cyc - start_cyc != (NPASS == 2 ? 19 : 10))
         $display("FAIL basic_latency: got %0d want %0d", done_cyc - start_cyc, NPASS == 2 ? 19 : 10);
      else n_pass++;
      n_checks++;
      if (err_at_done !== 1'b0 || cnt_at_done !== 16'd0) $display("FAIL basic_err: got err=%b cnt=%0d want 0/0", err_at_done, cnt_at_done);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1) $display("FAIL basic_done_pulses: got %0d want 1", done_cnt);
      else n_pass++;
   endtask

   task automatic test_error();
      bit ok;
      fault_en = 1'b1; fault_addr = 15'h0012;
      start_test(15'h0010, 16'd4, 32'hA5A5A5A5);
      wait_done(60, ok);
      fault_en = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL err_done_timeout: no done, want done");
      else n_pass++;
      n_checks++;
      if (err_at_done !== 1'b1 || cnt_at_done !== 16'(NPASS) || fea_at_done !== 15'h0012)
         $display("FAIL err_result: got err=%b cnt=%0d fea=%h want 1/%0d/0012", err_at_done, cnt_at_done, fea_at_done, NPASS);
      else n_pass++;
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (err !== 1'b1 || err_count !== 16'(NPASS) || first_err_addr !== 15'h0012)
         $display("FAIL err_hold: got err=%b cnt=%0d fea=%h want 1/%0d/0012", err, err_count, first_err_addr, NPASS);
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic [14:0] exp_a [4];
      bit ok;
      exp_a = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
      start_test(15'h7FFE, 16'd4, 32'h0);
      wait_done(60, ok);
      n_checks++;
      if (!ok || acc_q.size() != 8 * NPASS) $display("FAIL wrap_count: got done=%b n=%0d want 1/%0d", ok, acc_q.size(), 8 * NPASS);
      else n_pass++;
      for (int k = 0; k < acc_q.size() && k < 8 * NPASS; k++) begin
         n_checks++;
         if (acc_q[k].addr !== exp_a[k % 4] || acc_q[k].wr !== ((k % 8) < 4))
            $display("FAIL wrap_addr[%0d]: got wr=%b addr=%h want wr=%b addr=%h", k, acc_q[k].wr, acc_q[k].addr,
                     (k % 8) < 4, exp_a[k % 4]);
         else n_pass++;
      end
      n_checks++;
      if (err_at_done !== 1'b0 || cnt_at_done !== 16'd0 || fea_at_done !== 15'h0)
         $display("FAIL wrap_err_cleared: got err=%b cnt=%0d fea=%h want 0/0/0", err_at_done, cnt_at_done, fea_at_done);
      else n_pass++;
   endtask

   task automatic test_zero();
      bit ok;
      start_test(15'h0123, 16'd0, 32'h12345678);
      wait_done(20, ok);
      repeat (3) @(posedge clk);
      n_checks++;
      if (!ok || done_cyc - start_cyc != 1) $display("FAIL zero_latency: got done=%b lat=%0d want 1/1", ok, done_cyc - start_cyc);
      else n_pass++;
      n_checks++;
      if (busy_cnt != 1) $display("FAIL zero_busy: got %0d cycles want 1", busy_cnt);
      else n_pass++;
      n_checks++;
      if (acc_q.size() != 0) $display("FAIL zero_bus: got %0d accesses want 0", acc_q.size());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d [4];
      bit ok;
      exp_d = '{32'hA5A5A5B5, 32'hA5A5A5B4, 32'hA5A5A5B7, 32'hA5A5A5B6};
      start_test(15'h0010, 16'd4, 32'hA5A5A5A5);
      @(posedge clk); #1;
      base_addr = 15'h0040; word_count = 16'd2; seed = 32'h0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(60, ok);
      n_checks++;
      if (!ok || done_cyc - start_cyc != (NPASS == 2 ? 19 : 10) || acc_q.size() != 8 * NPASS)
         $display("FAIL b2b_shape: got done=%b lat=%0d n=%0d want 1/%0d/%0d", ok, done_cyc - start_cyc, acc_q.size(),
                  NPASS == 2 ? 19 : 10, 8 * NPASS);
      else n_pass++;
      for (int k = 0; k < acc_q.size() && k < 4; k++) begin
         n_checks++;
         if (acc_q[k].addr !== 15'(16 + k) || acc_q[k].data !== exp_d[k])
            $display("FAIL b2b_write[%0d]: got addr=%h data=%h want %h/%h", k, acc_q[k].addr, acc_q[k].data, 15'(16 + k), exp_d[k]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      int n_acc;
      start_test(15'h0100, 16'd8, 32'h12345678);
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (m_chipselect && !m_write) seen = 1;
      end
      reset_n = 1'b0;
      n_checks++;
      if (!seen) $display("FAIL rstmid_read_seen: no read phase, want read");
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({busy, done, err, err_count, first_err_addr, m_chipselect, m_write, m_address, m_writedata} !== 83'd0)
         $display("FAIL rstmid_outputs: got busy=%b done=%b err=%b cnt=%h fea=%h cs=%b wr=%b addr=%h wd=%h, want all 0",
                  busy, done, err, err_count, first_err_addr, m_chipselect, m_write, m_address, m_writedata);
      else n_pass++;
      n_acc = acc_q.size();
      @(posedge clk); #1; reset_n = 1'b1;
      repeat (30) @(posedge clk);
      n_checks++;
      if (done_cnt != 0 || acc_q.size() != n_acc)
         $display("FAIL rstmid_aborted: got done=%0d extra_acc=%0d want 0/0", done_cnt, acc_q.size() - n_acc);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_error();
      test_wrap();
      test_zero();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
